rx_edge_sampler: RTL

Oversampling timebase and bit sampler for the UART receiver, directly upstream of the receive FSM. Counts oversampling clock edges within each bit period and bit positions within a frame, and produces a majority-voted sampled bit per bit period. The FSM consumes `edge_count` and `bit_count` to sequence a frame. Start, parity, stop and deserializer logic consume `sampled_bit`.

---
 rtl/rx_edge_sampler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rx_edge_sampler.sv
// Oversampling timebase and 3-point majority bit sampler for the UART receiver.
// Optional input synchronizer enabled by defining RX_SYNC_EN.
module rx_edge_sampler #(
   parameter int PRESCALE_W = 6,
   parameter int EDGE_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  counter_en,
   input  logic                  data_sample_en,
   output logic [EDGE_W-1:0]     edge_count,
   output logic [3:0]            bit_count,
   output logic                  sampled_bit,
   output logic                  sample_valid
);

   // One extra bit so half-1 for a tiny prescale underflows out of range instead of aliasing
   localparam int CW = ((PRESCALE_W > EDGE_W) ? PRESCALE_W : EDGE_W) + 1;

   logic [EDGE_W-1:0] edge_count_q, edge_count_d;
   logic [3:0]        bit_count_q, bit_count_d;
   logic              s0_q, s0_d;
   logic              s1_q, s1_d;
   logic              sampled_bit_q, sampled_bit_d;
   logic              sample_valid_q, sample_valid_d;

   logic [EDGE_W-1:0] last_edge;
   logic [3:0]        frame_last;
   logic [CW-1:0]     edge_ext;
   logic [CW-1:0]     half_ext;
   logic              rxs;
   logic              vote;

`ifdef RX_SYNC_EN
   logic rx_meta_q, rx_meta_d;
   logic rx_sync_q, rx_sync_d;

   always_comb begin
      rx_meta_d = rx_in;
      rx_sync_d = rx_meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_sync_q <= rx_sync_d;
      end
   end

   assign rxs = rx_sync_q;
`else
   assign rxs = rx_in;
`endif

   assign last_edge  = EDGE_W'(prescale - PRESCALE_W'(1));
   assign frame_last = par_en ? 4'd10 : 4'd9;
   assign edge_ext   = CW'(edge_count_q);
   assign half_ext   = CW'(prescale >> 1);
   assign vote       = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

   // Comparisons use >= so an illegal mid-run prescale/par_en change still wraps
   always_comb begin
      edge_count_d = edge_count_q;
      bit_count_d  = bit_count_q;
      if (!counter_en) begin
         edge_count_d = '0;
         bit_count_d  = '0;
      end else begin
         if (edge_count_q == last_edge) begin
            bit_count_d = (bit_count_q >= frame_last) ? '0 : bit_count_q + 4'd1;
         end
         edge_count_d = (edge_count_q >= last_edge) ? '0 : edge_count_q + EDGE_W'(1);
      end
   end

   always_comb begin
      s0_d           = s0_q;
      s1_d           = s1_q;
      sampled_bit_d  = sampled_bit_q;
      sample_valid_d = 1'b0;
      if (data_sample_en) begin
         if (edge_ext == half_ext - CW'(1)) s0_d = rxs;
         if (edge_ext == half_ext)          s1_d = rxs;
         if (edge_ext == half_ext + CW'(1)) begin
            sampled_bit_d  = vote;
            sample_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_count_q   <= '0;
         bit_count_q    <= '0;
         s0_q           <= 1'b1;
         s1_q           <= 1'b1;
         sampled_bit_q  <= 1'b1;
         sample_valid_q <= 1'b0;
      end else begin
         edge_count_q   <= edge_count_d;
         bit_count_q    <= bit_count_d;
         s0_q           <= s0_d;
         s1_q           <= s1_d;
         sampled_bit_q  <= sampled_bit_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign edge_count   = edge_count_q;
   assign bit_count    = bit_count_q;
   assign sampled_bit  = sampled_bit_q;
   assign sample_valid = sample_valid_q;

endmodule
